// File: rtl/cpc_serial_port.sv
// cpc_serial_port: Z80 I/O-mapped 8N1 UART with a 1-byte TX holding register, RX FIFO and level irq; io_din is combinational.
// Writes act one clk after io_wr rises, reads pop on io_rd fall; no stalls: a full holding register drops writes, a full FIFO drops RX bytes and sets ovr.

module cpc_serial_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok  = push && (count != FULL);
  assign pop_ok   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module cpc_serial_port #(
  parameter logic [15:0] BASE_ADDR  = 16'hF8E0,
  parameter logic [15:0] DIV_RESET  = 16'd277,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  io_dout,
  input  logic        io_rd,
  input  logic        io_wr,
  output logic [7:0]  io_din,
  output logic        irq,
  output logic        txd,
  input  logic        rxd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic          sel, io_wr_q, io_rd_q, rd_sel_q;
  logic [1:0]    rd_idx_q;
  logic          wr_stb, rd_rise, rd_done, pop, stat_clr, flush;
  logic          rx_ie, tx_ie, ovr, ferr;
  logic [15:0]   divisor;
  logic [7:0]    thr_dat;
  logic          thr_full, thr_empty, tx_idle;
  logic          rx_avail, rx_full;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_head, status;

  tx_state_t     tx_state, tx_next;
  logic          tx_load, tx_tick;
  logic [15:0]   tx_cnt, tx_div;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_s3, rx_edge, rx_tick, rx_push;
  logic [15:0]   rx_cnt, rx_div, rx_mid, mid_now;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  assign sel      = cpu_addr[15:2] == BASE_ADDR[15:2];
  assign wr_stb   = io_wr & ~io_wr_q & sel;
  assign rd_rise  = io_rd & ~io_rd_q;
  assign rd_done  = ~io_rd & io_rd_q & rd_sel_q;
  assign pop      = rd_done && (rd_idx_q == 2'd0);
  assign stat_clr = rd_done && (rd_idx_q == 2'd1);
  assign flush    = wr_stb && (cpu_addr[1:0] == 2'd1) && io_dout[7];

  assign thr_empty = ~thr_full;
  assign tx_idle   = (tx_state == TX_IDLE) & ~thr_full;
  assign rx_avail  = rx_count != '0;
  assign rx_full   = rx_count == FIFO_FULL;
  assign status    = {2'b00, rx_full, ferr, ovr, tx_idle, thr_empty, rx_avail};

  always_comb begin
    io_din = 8'hFF;
    if (io_rd && sel) begin
      case (cpu_addr[1:0])
        2'd0:    io_din = rx_avail ? rx_head : 8'h00;
        2'd1:    io_din = status;
        2'd2:    io_din = divisor[7:0];
        default: io_din = divisor[15:8];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_wr_q  <= 1'b0;
      io_rd_q  <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_idx_q <= 2'd0;
      rx_ie    <= 1'b0;
      tx_ie    <= 1'b0;
      divisor  <= DIV_RESET;
      thr_dat  <= 8'h00;
      thr_full <= 1'b0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      io_wr_q <= io_wr;
      io_rd_q <= io_rd;
      if (rd_rise) begin
        rd_sel_q <= sel;
        rd_idx_q <= cpu_addr[1:0];
      end
      if (wr_stb) begin
        case (cpu_addr[1:0])
          2'd0: if (!thr_full) begin
            thr_dat  <= io_dout;
            thr_full <= 1'b1;
          end
          2'd1: begin
            rx_ie <= io_dout[0];
            tx_ie <= io_dout[1];
          end
          2'd2:    divisor[7:0]  <= io_dout;
          default: divisor[15:8] <= io_dout;
        endcase
      end
      if (tx_load) thr_full <= 1'b0;
      if (flush || stat_clr) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
      end
      // A new error on the clearing clk must not be lost, so sets come last.
      if (rx_push && rx_full) ovr  <= 1'b1;
      if (rx_push && !rx_s2)  ferr <= 1'b1;
      irq <= (rx_ie & rx_avail) | (tx_ie & thr_empty) | ovr | ferr;
    end
  end

  // Transmitter
  assign tx_tick = tx_cnt == tx_div;

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE: if (thr_full) begin
        tx_next = TX_START;
        tx_load = 1'b1;
      end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP: if (tx_tick) begin
        tx_next = thr_full ? TX_START : TX_IDLE;
        tx_load = thr_full;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      tx_state <= tx_next;
      if (tx_load) begin
        tx_shift <= thr_dat;
        tx_div   <= divisor;
        tx_cnt   <= 16'd0;
        tx_bit   <= 3'd0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= 16'd0;
          if (tx_state == TX_DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  // Decoded from state so reset forces the line high without waiting for a clk.
  assign txd = (tx_state == TX_START) ? 1'b0 :
               (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  // Receiver; start sample lands (divisor+1)/2 clk after the edge clk.
  assign mid_now = {1'b0, divisor[15:1]} + {15'd0, divisor[0]};
  assign rx_edge = rx_s3 & ~rx_s2;
  assign rx_tick = rx_cnt == rx_div;

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    case (rx_state)
      RX_HUNT:  if (rx_edge) rx_next = (mid_now == 16'd0) ? RX_DATA : RX_START;
      RX_START: if (rx_cnt == rx_mid) rx_next = rx_s2 ? RX_HUNT : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: if (rx_tick) begin
        rx_next = RX_HUNT;
        rx_push = 1'b1;
      end
      default: rx_next = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_HUNT;
      rx_cnt   <= 16'd0;
      rx_div   <= 16'd0;
      rx_mid   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_next;
      case (rx_state)
        RX_HUNT: if (rx_edge) begin
          rx_div <= divisor;
          rx_mid <= mid_now;
          rx_cnt <= (mid_now == 16'd0) ? 16'd0 : 16'd1;
          rx_bit <= 3'd0;
        end
        RX_START: rx_cnt <= (rx_cnt == rx_mid) ? 16'd0 : rx_cnt + 16'd1;
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
      endcase
    end
  end

  cpc_serial_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (rx_push),
    .push_dat (rx_shift),
    .pop      (pop),
    .head_dat (rx_head),
    .count    (rx_count)
  );
endmodule

// File: tb/tb_cpc_serial_port.sv
// Randomized scoreboard bench for cpc_serial_port: a queue-based port model predicts reads and TX frames; monitors compare.
module tb_cpc_serial_port;
  localparam logic [15:0] BASE = 16'hF8E0;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  io_dout = 8'h00;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic        rxd = 1'b1;
  logic [7:0]  io_din;
  logic        irq;
  logic        txd;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  cpc_serial_port dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .io_dout(io_dout),
    .io_rd(io_rd), .io_wr(io_wr), .io_din(io_din), .irq(irq), .txd(txd), .rxd(rxd)
  );

  // Behavioural port model
  logic [7:0]  m_rxq[$];
  logic        m_ovr, m_ferr, m_rx_ie, m_tx_ie;
  logic [15:0] m_div;

  logic [7:0]  rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  int          tx_starts[$];
  bit          tx_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {2'b00, m_rxq.size() == DEPTH, m_ferr, m_ovr, 1'b1, 1'b1, m_rxq.size() != 0};
  endfunction

  function automatic logic m_irq();
    return (m_rx_ie && m_rxq.size() != 0) || m_tx_ie || m_ovr || m_ferr;
  endfunction

  task automatic m_reset();
    m_rxq.delete();
    m_ovr = 0; m_ferr = 0; m_rx_ie = 0; m_tx_ie = 0;
    m_div = 16'd277;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d, input int hold);
    cpu_addr = addr; io_dout = d; io_wr = 1'b1;
    cyc(hold);
    io_wr = 1'b0;
    cyc(2);
    if (addr[15:2] == BASE[15:2]) begin
      case (addr[1:0])
        2'd1: begin
          if (d[7]) begin m_rxq.delete(); m_ovr = 0; m_ferr = 0; end
          m_rx_ie = d[0]; m_tx_ie = d[1];
        end
        2'd2: m_div[7:0] = d;
        2'd3: m_div[15:8] = d;
        default: ;
      endcase
    end
  endtask

  task automatic cpu_read(input logic [15:0] addr, input int hold, input string name);
    logic [7:0] e;
    e = 8'hFF;
    if (addr[15:2] == BASE[15:2]) begin
      case (addr[1:0])
        2'd0: e = (m_rxq.size() != 0) ? m_rxq.pop_front() : 8'h00;
        2'd1: begin e = m_status(); m_ovr = 0; m_ferr = 0; end
        2'd2: e = m_div[7:0];
        default: e = m_div[15:8];
      endcase
    end
    rd_exp_q.push_back(e);
    rd_name_q.push_back(name);
    cpu_addr = addr; io_rd = 1'b1;
    cyc(hold);
    io_rd = 1'b0;
    cyc(2);
  endtask

  task automatic rx_bit(input logic v, input int bp);
    rxd = v;
    cyc(bp);
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit stop_ok);
    int bp;
    bp = int'(m_div) + 1;
    rx_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) rx_bit(d[i], bp);
    rx_bit(stop_ok, bp);
    if (!stop_ok) rx_bit(1'b1, bp);
    cyc(6);
    if (m_rxq.size() < DEPTH) m_rxq.push_back(d);
    else m_ovr = 1;
    if (!stop_ok) m_ferr = 1;
  endtask

  task automatic tx_send(input logic [7:0] d, input int hold);
    tx_exp_q.push_back(d);
    cpu_write(BASE, d, hold);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || tx_busy) && n < budget) begin
      cyc(1);
      n++;
    end
    check("tx_drain_in_budget", n < budget, 1);
  endtask

  task automatic check_irq(input string name);
    cyc(2);
    check(name, irq, m_irq());
  endtask

  // Read monitor: one comparison per io_rd strobe.
  initial begin : rd_mon
    bit seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (io_rd && !seen) begin
        seen = 1;
        if (rd_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got %0h want no read", io_din);
        end else begin
          check(rd_name_q.pop_front(), io_din, rd_exp_q.pop_front());
        end
      end else if (!io_rd) begin
        seen = 0;
      end
    end
  end

  // TX monitor: samples every clk, requires each bit to hold for exactly divisor+1 clks.
  initial begin : tx_mon
    int k, bp;
    logic [9:0] fr;
    logic [7:0] e;
    bit glitch;
    logic prev;
    k = 0; bp = 1; fr = '0; glitch = 0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        tx_busy = 0;
        prev = 1'b1;
      end else begin
        if (!tx_busy && prev && !txd) begin
          tx_busy = 1; k = 0; bp = int'(m_div) + 1; glitch = 0; fr = '0;
          tx_starts.push_back(cycle);
        end
        if (tx_busy) begin
          if (k % bp == 0) fr[k / bp] = txd;
          else if (txd !== fr[k / bp]) glitch = 1;
          k++;
          if (k == 10 * bp) begin
            tx_busy = 0;
            if (tx_exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL tx_unexpected: got frame %0h want none", fr);
            end else begin
              e = tx_exp_q.pop_front();
              check("tx_frame", {glitch, fr}, {1'b0, 1'b1, e, 1'b0});
            end
          end
        end
        prev = txd;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b1, b2, b3, d;
    int n;
    m_reset();
    cyc(4);
    check("reset_txd", txd, 1);
    check("reset_irq", irq, 0);
    check("reset_io_din", io_din, 8'hFF);
    reset_n = 1'b1;
    cyc(3);

    cpu_read(BASE + 16'd1, 3, "reset_status");
    cpu_read(16'hF8E4, 3, "unselected_read");
    cpu_read(16'h00E1, 3, "unselected_read2");
    cpu_read(BASE + 16'd2, 3, "div_lo_reset");
    cpu_read(BASE + 16'd3, 3, "div_hi_reset");
    check("idle_txd", txd, 1);
    check_irq("idle_irq");

    // TX at divisor 3, long write strobe
    cpu_write(BASE + 16'd2, 8'h03, 3);
    cpu_write(BASE + 16'd3, 8'h00, 3);
    cpu_read(BASE + 16'd2, 3, "div_lo_written");
    tx_send(8'hA5, 20);
    wait_tx_drain(200);
    cpu_read(BASE + 16'd1, 3, "status_after_tx");

    // Back-to-back: third write hits a full holding register and is dropped
    tx_starts.delete();
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    tx_exp_q.push_back(b1); tx_exp_q.push_back(b2);
    cpu_write(BASE, b1, 2);
    cpu_write(BASE, b2, 2);
    cpu_write(BASE, b3, 2);
    wait_tx_drain(300);
    check("b2b_frame_count", tx_starts.size(), 2);
    if (tx_starts.size() >= 2) check("b2b_gap", tx_starts[1] - tx_starts[0], 40);
    for (int i = 0; i < 3; i++) begin
      tx_send(8'($urandom), 3);
      wait_tx_drain(200);
    end

    // RX basic, long read strobe pops once
    rx_frame(8'h3C, 1);
    rx_frame(8'hC3, 1);
    cpu_read(BASE + 16'd1, 3, "status_rx_avail");
    cpu_read(BASE, 20, "rx_first");
    cpu_read(BASE, 3, "rx_second");
    cpu_read(BASE, 3, "rx_empty");
    cpu_read(BASE + 16'd1, 3, "status_rx_drained");

    // One-clk low glitch must not produce a byte
    rxd = 1'b0; cyc(1); rxd = 1'b1; cyc(20);
    cpu_read(BASE + 16'd1, 3, "status_after_glitch");

    // Overflow
    for (int i = 0; i < 5; i++) rx_frame(8'($urandom), 1);
    check_irq("irq_overflow");
    for (int i = 0; i < 4; i++) cpu_read(BASE, 3, "rx_overflow_data");
    cpu_read(BASE + 16'd1, 3, "status_ovr_set");
    cpu_read(BASE + 16'd1, 3, "status_ovr_cleared");
    check_irq("irq_after_ovr_clear");

    // Framing error, flush, then framing error with the byte kept
    rx_frame(8'h55, 0);
    check_irq("irq_ferr");
    cpu_write(BASE + 16'd1, 8'h80, 3);
    check_irq("irq_after_flush");
    cpu_read(BASE + 16'd1, 3, "status_after_flush");
    rx_frame(8'hAA, 0);
    cpu_read(BASE + 16'd1, 3, "status_ferr");
    cpu_read(BASE, 3, "ferr_byte_kept");

    // Interrupt enables
    cpu_write(BASE + 16'd1, 8'h02, 3);
    check_irq("irq_tx_ie");
    cpu_write(BASE + 16'd1, 8'h01, 3);
    check_irq("irq_rx_ie_empty");
    rx_frame(8'($urandom), 1);
    check_irq("irq_rx_ie_avail");
    cpu_read(BASE, 3, "rx_ie_data");
    check_irq("irq_rx_ie_drained");
    cpu_write(BASE + 16'd1, 8'h00, 3);

    // Random divisors, including 0 (1-clk bits)
    for (int r = 0; r < 3; r++) begin
      d = (r == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      cpu_write(BASE + 16'd2, d, 3);
      cpu_write(BASE + 16'd3, 8'h00, 3);
      rx_frame(8'($urandom), 1);
      rx_frame(8'($urandom), 1);
      tx_send(8'($urandom), 3);
      wait_tx_drain(300);
      cpu_read(BASE, 3, "rx_rand_div");
      cpu_read(BASE, 3, "rx_rand_div");
      cpu_read(BASE + 16'd1, 3, "status_rand_div");
    end

    // Reset during data bit 3 of 8'hA5 (bit 3 is 0)
    cpu_write(BASE + 16'd2, 8'h03, 3);
    cpu_addr = BASE; io_dout = 8'hA5; io_wr = 1'b1;
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    check("rst_tx_started", n < 20, 1);
    io_wr = 1'b0;
    cyc(17);
    check("rst_bit3_low", txd, 0);
    reset_n = 1'b0;
    #1;
    check("rst_txd_immediate", txd, 1);
    m_reset();
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    cpu_read(BASE + 16'd1, 3, "status_after_rst");
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) n++;
      cyc(1);
    end
    check("no_residual_frame", n, 0);
    check_irq("irq_after_rst");

    check("rd_queue_empty", rd_exp_q.size(), 0);
    check("tx_queue_empty", tx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
